// File: rtl/ascii_stream_stats.sv
// ascii_stream_stats
//
// Streaming per-string character statistics engine. It accepts one ASCII
// byte per cycle over a valid/ready handshake. Each byte is classified into
// the character class chosen by class_sel, which is captured on the first
// byte of a string. When a terminator (0x00 or 0x0A) is accepted, the block
// reports the string length, the class match count, the word count and the
// longest consecutive class run over a second valid/ready handshake. All
// counters saturate at 2^CNT_W-1. The ovf flag records that saturation
// happened at some point during the string.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_char is valid this cycle
//   in_ready   out  block can take in_char (decoded from registered state)
//   in_char    in   ASCII byte
//   class_sel  in   class code, sampled on the first byte of a string
//   out_valid  out  result fields valid
//   out_ready  in   consumer takes the result
//   len        out  non-terminator bytes in the string
//   match_cnt  out  bytes in the selected class
//   word_cnt   out  maximal non-whitespace runs
//   max_run    out  longest run of consecutive selected-class bytes
//   ovf        out  some counter saturated during this string

module ascii_stream_stats #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic [3:0]       class_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] max_run,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] len_q, match_q, word_q, max_q, run_q;
  logic             ovf_q;
  logic [3:0]       sel_q;
  logic             prev_ws_q;

  // Character decode of the incoming byte
  logic is_lower, is_upper, is_digit, is_hex, is_letter;
  logic is_punct, is_sym, is_brk, is_brace, is_op, is_ws, is_vowel, is_term;
  logic [3:0] eff_sel;
  logic class_hit;

  // Datapath control
  logic accept, do_proc, clear, word_start, ovf_event;
  logic [CNT_W-1:0] run_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
  assign is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
  assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_letter = is_lower || is_upper;
  assign is_hex    = is_digit
                   || ((in_char >= 8'h41) && (in_char <= 8'h46))
                   || ((in_char >= 8'h61) && (in_char <= 8'h66));

  // . , : ; ! ? ' "
  assign is_punct = (in_char == 8'h2E) || (in_char == 8'h2C) || (in_char == 8'h3A)
                 || (in_char == 8'h3B) || (in_char == 8'h21) || (in_char == 8'h3F)
                 || (in_char == 8'h27) || (in_char == 8'h22);
  // # $ % & @
  assign is_sym   = (in_char == 8'h23) || (in_char == 8'h24) || (in_char == 8'h25)
                 || (in_char == 8'h26) || (in_char == 8'h40);
  // ( ) [ ]
  assign is_brk   = (in_char == 8'h28) || (in_char == 8'h29) || (in_char == 8'h5B)
                 || (in_char == 8'h5D);
  // { }
  assign is_brace = (in_char == 8'h7B) || (in_char == 8'h7D);
  // + - * / \ = < >
  assign is_op    = (in_char == 8'h2B) || (in_char == 8'h2D) || (in_char == 8'h2A)
                 || (in_char == 8'h2F) || (in_char == 8'h5C) || (in_char == 8'h3D)
                 || (in_char == 8'h3C) || (in_char == 8'h3E);
  assign is_ws    = (in_char == 8'h20) || (in_char == 8'h09) || (in_char == 8'h0A)
                 || (in_char == 8'h0D);
  assign is_vowel = (in_char == 8'h61) || (in_char == 8'h65) || (in_char == 8'h69)
                 || (in_char == 8'h6F) || (in_char == 8'h75) || (in_char == 8'h41)
                 || (in_char == 8'h45) || (in_char == 8'h49) || (in_char == 8'h4F)
                 || (in_char == 8'h55);
  assign is_term  = (in_char == 8'h00) || (in_char == 8'h0A);

  // The first byte of a string is classified with the live class_sel. That
  // same value is latched, so later bytes ignore changes on class_sel.
  assign eff_sel = (state_q == IDLE) ? class_sel : sel_q;

  always_comb begin
    class_hit = 1'b0;
    case (eff_sel)
      4'd0:    class_hit = is_lower;
      4'd1:    class_hit = is_upper;
      4'd2:    class_hit = is_digit;
      4'd3:    class_hit = is_hex;
      4'd4:    class_hit = is_punct;
      4'd5:    class_hit = is_sym;
      4'd6:    class_hit = is_brk;
      4'd7:    class_hit = is_brace;
      4'd8:    class_hit = is_op;
      4'd9:    class_hit = is_ws;
      4'd10:   class_hit = is_vowel;
      4'd11:   class_hit = is_letter && !is_vowel;
      4'd12:   class_hit = !(is_letter || is_digit || is_punct || is_sym || is_brk
                             || is_brace || is_op || is_ws);
      default: class_hit = 1'b0;
    endcase
  end

  assign in_ready  = (state_q != REPORT);
  assign out_valid = (state_q == REPORT);

  assign accept  = in_valid && in_ready;
  assign do_proc = accept && !is_term;
  assign clear   = (state_q == REPORT) && out_ready;

  // In IDLE the first byte counts as a word start on its own. After that, a
  // word starts on a non-whitespace byte that follows whitespace.
  assign word_start = !is_ws && ((state_q == IDLE) || prev_ws_q);
  assign run_next   = class_hit ? sat_inc(run_q) : '0;
  assign ovf_event  = (len_q == CNT_MAX)
                   || (class_hit && ((match_q == CNT_MAX) || (run_q == CNT_MAX)))
                   || (word_start && (word_q == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_term ? REPORT : ACCUM;
      ACCUM:   if (accept && is_term) state_d = REPORT;
      REPORT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters clear when the report is consumed. Because of that, every
  // string starts from zero, and an empty string reports all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      match_q   <= '0;
      word_q    <= '0;
      max_q     <= '0;
      run_q     <= '0;
      ovf_q     <= 1'b0;
      sel_q     <= '0;
      prev_ws_q <= 1'b0;
    end else if (clear) begin
      len_q     <= '0;
      match_q   <= '0;
      word_q    <= '0;
      max_q     <= '0;
      run_q     <= '0;
      ovf_q     <= 1'b0;
      sel_q     <= '0;
      prev_ws_q <= 1'b0;
    end else if (do_proc) begin
      if (state_q == IDLE) sel_q <= class_sel;
      len_q <= sat_inc(len_q);
      if (class_hit) match_q <= sat_inc(match_q);
      run_q <= run_next;
      if (run_next > max_q) max_q <= run_next;
      if (word_start) word_q <= sat_inc(word_q);
      prev_ws_q <= is_ws;
      if (ovf_event) ovf_q <= 1'b1;
    end
  end

  assign len       = len_q;
  assign match_cnt = match_q;
  assign word_cnt  = word_q;
  assign max_run   = max_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ascii_stream_stats.sv
// tb_ascii_stream_stats
//
// This bench drives two copies of ascii_stream_stats (CNT_W=8 and CNT_W=4)
// from the same byte stream and checks the reports of both.
// The first part is a table of known strings with hand-computed results.
// A reset-mid-string sequence follows.
// The last part uses random strings, and a string-level reference model
// gives the expected results.

module tb_ascii_stream_stats;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic [3:0] class_sel = 4'd0;
  logic       out_ready = 1'b0;

  logic       in_ready_w, out_valid_w, ovf_w;
  logic [7:0] len_w, match_w, word_w, run_w;
  logic       in_ready_n, out_valid_n, ovf_n;
  logic [3:0] len_n, match_n, word_n, run_n;

  ascii_stream_stats #(.CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_char(in_char), .class_sel(class_sel), .out_valid(out_valid_w),
    .out_ready(out_ready), .len(len_w), .match_cnt(match_w), .word_cnt(word_w),
    .max_run(run_w), .ovf(ovf_w)
  );

  ascii_stream_stats #(.CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_char(in_char), .class_sel(class_sel), .out_valid(out_valid_n),
    .out_ready(out_ready), .len(len_n), .match_cnt(match_n), .word_cnt(word_n),
    .max_run(run_n), .ovf(ovf_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int match;
    int words;
    int mrun;
    int ovf;
  } res_t;

  typedef struct {
    int         sel;
    logic [7:0] term;
    bit         gaps;
    int         hold;
    res_t       w;
    res_t       n;
  } vec_t;

  vec_t  tbl[12];
  string tbl_text[12];

  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_set(input string set, input logic [7:0] c);
    for (int i = 0; i < set.len(); i++)
      if (set[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_class(input logic [7:0] c, input int sel);
    bit lo = (c >= 8'h61) && (c <= 8'h7A);
    bit up = (c >= 8'h41) && (c <= 8'h5A);
    bit dg = (c >= 8'h30) && (c <= 8'h39);
    bit hx = dg || ((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66));
    bit pu = in_set(".,:;!?'\"", c);
    bit sy = in_set("#$%&@", c);
    bit br = in_set("()[]", c);
    bit bc = in_set("{}", c);
    bit op = in_set("+-*/\\=<>", c);
    bit ws = in_set(" \t\n\r", c);
    bit vw = in_set("aeiouAEIOU", c);
    case (sel)
      0:       return lo;
      1:       return up;
      2:       return dg;
      3:       return hx;
      4:       return pu;
      5:       return sy;
      6:       return br;
      7:       return bc;
      8:       return op;
      9:       return ws;
      10:      return vw;
      11:      return (lo || up) && !vw;
      12:      return !(lo || up || dg || pu || sy || br || bc || op || ws);
      default: return 1'b0;
    endcase
  endfunction

  // String-level reference model. It computes the true counts first, then
  // clips each one at maxv.
  function automatic res_t model(input string s, input int sel, input int maxv);
    res_t r;
    int m = 0, w = 0, run = 0, best = 0;
    bit prev_ws = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      bit ws = in_set(" \t\r\n", s[i]);
      if (model_class(s[i], sel)) begin
        m++;
        run++;
      end else begin
        run = 0;
      end
      if (run > best) best = run;
      if (!ws && prev_ws) w++;
      prev_ws = ws;
    end
    r.len   = (s.len() > maxv) ? maxv : s.len();
    r.match = (m > maxv) ? maxv : m;
    r.words = (w > maxv) ? maxv : w;
    r.mrun  = (best > maxv) ? maxv : best;
    r.ovf   = (s.len() > maxv || m > maxv || w > maxv || best > maxv) ? 1 : 0;
    return r;
  endfunction

  function automatic res_t mk(input int l, input int m, input int w, input int r, input int o);
    res_t x;
    x.len = l; x.match = m; x.words = w; x.mrun = r; x.ovf = o;
    return x;
  endfunction

  // Offer one byte and wait until it is accepted. Optionally insert a few
  // cycles of idle input first.
  task automatic applyStimulus(input logic [7:0] c, input logic [3:0] sel, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_char  = 8'($urandom);
      end
    end
    @(negedge clk);
    cmp("no_report_mid_string", out_valid_w, 0);
    in_valid  = 1'b1;
    in_char   = c;
    class_sel = sel;
    while (!in_ready_w && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) cmp("in_ready_timeout", in_ready_w, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic sendString(input string s, input logic [7:0] term, input int sel, input bit gaps);
    for (int i = 0; i < s.len(); i++)
      applyStimulus(s[i], (i == 0) ? 4'(sel) : 4'($urandom_range(0, 15)), gaps);
    applyStimulus(term, (s.len() == 0) ? 4'(sel) : 4'($urandom_range(0, 15)), gaps);
  endtask

  // Expects the report one cycle after the terminator was accepted.
  // Holds out_ready low for hold cycles and checks that the report stays
  // stable. Then consumes the report and checks the return to idle.
  task automatic checkOutput(input string name, input res_t ew, input res_t en, input int hold);
    int guard = 0;
    @(negedge clk);
    cmp({name, ".latency"}, out_valid_w, 1);
    while (!out_valid_w && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int h = 0; h <= hold; h++) begin
      cmp({name, ".out_valid"}, out_valid_w, 1);
      cmp({name, ".in_ready"}, in_ready_w, 0);
      cmp({name, ".len"}, len_w, ew.len);
      cmp({name, ".match"}, match_w, ew.match);
      cmp({name, ".words"}, word_w, ew.words);
      cmp({name, ".max_run"}, run_w, ew.mrun);
      cmp({name, ".ovf"}, ovf_w, ew.ovf);
      cmp({name, ".n_out_valid"}, out_valid_n, 1);
      cmp({name, ".n_len"}, len_n, en.len);
      cmp({name, ".n_match"}, match_n, en.match);
      cmp({name, ".n_words"}, word_n, en.words);
      cmp({name, ".n_max_run"}, run_n, en.mrun);
      cmp({name, ".n_ovf"}, ovf_n, en.ovf);
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    cmp({name, ".ready_after"}, in_ready_w, 1);
    cmp({name, ".valid_after"}, out_valid_w, 0);
    cmp({name, ".len_cleared"}, len_w, 0);
    cmp({name, ".ovf_cleared"}, ovf_w, 0);
    cmp({name, ".n_ovf_cleared"}, ovf_n, 0);
  endtask

  task automatic addRow(input int idx, input string t, input int sel, input logic [7:0] term,
                        input bit gaps, input int hold, input res_t w);
    tbl_text[idx]  = t;
    tbl[idx].sel   = sel;
    tbl[idx].term  = term;
    tbl[idx].gaps  = gaps;
    tbl[idx].hold  = hold;
    tbl[idx].w     = w;
    tbl[idx].n     = w;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string s;
    string a20;
    string b300;
    res_t  ew, en;

    a20 = "";
    for (int i = 0; i < 20; i++) a20 = {a20, "a"};
    b300 = "";
    for (int i = 0; i < 300; i++) b300 = {b300, "b"};

    addRow(0,  "Hi there",  10, 8'h00, 0, 0, mk(8, 3, 2, 1, 0));
    addRow(1,  "Hi there",  11, 8'h00, 0, 0, mk(8, 4, 2, 2, 0));
    addRow(2,  "  a  b ",   9,  8'h0A, 0, 0, mk(7, 5, 2, 2, 0));
    addRow(3,  "DEADbeef7", 3,  8'h00, 0, 0, mk(9, 9, 1, 9, 0));
    addRow(4,  a20,         0,  8'h0A, 0, 0, mk(20, 20, 1, 20, 0));
    tbl[4].n = mk(15, 15, 1, 15, 1);
    addRow(5,  "x",         0,  8'h0A, 0, 0, mk(1, 1, 1, 1, 0));
    addRow(6,  "",          0,  8'h00, 0, 5, mk(0, 0, 0, 0, 0));
    addRow(7,  "abc",       0,  8'h0A, 1, 0, mk(3, 3, 1, 3, 0));
    addRow(8,  b300,        0,  8'h00, 0, 1, mk(255, 255, 1, 255, 1));
    tbl[8].n = mk(15, 15, 1, 15, 1);
    addRow(9,  "a+b=(c)",   8,  8'h0A, 0, 0, mk(7, 2, 1, 1, 0));
    addRow(10, "x^_~|y",    12, 8'h00, 1, 0, mk(6, 4, 1, 4, 0));
    addRow(11, "ab",        13, 8'h0A, 0, 0, mk(2, 0, 1, 0, 0));

    // Reset state
    #12;
    cmp("reset.in_ready", in_ready_w, 1);
    cmp("reset.out_valid", out_valid_w, 0);
    cmp("reset.len", len_w, 0);
    cmp("reset.match", match_w, 0);
    cmp("reset.words", word_w, 0);
    cmp("reset.max_run", run_w, 0);
    cmp("reset.ovf", ovf_w, 0);
    cmp("reset.n_in_ready", in_ready_n, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      sendString(tbl_text[i], tbl[i].term, tbl[i].sel, tbl[i].gaps);
      checkOutput($sformatf("row%0d", i), tbl[i].w, tbl[i].n, tbl[i].hold);
    end

    // Reset in the middle of a string discards it without a report
    applyStimulus(8'h61, 4'd0, 0);
    applyStimulus(8'h62, 4'd0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("midreset.len", len_w, 0);
    cmp("midreset.in_ready", in_ready_w, 1);
    cmp("midreset.out_valid", out_valid_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cmp("midreset.no_report", out_valid_w, 0);
    end
    sendString("z", 8'h0A, 0, 0);
    checkOutput("after_reset", mk(1, 1, 1, 1, 0), mk(1, 1, 1, 1, 0), 0);

    // Random strings checked against the reference model
    for (int r = 0; r < 40; r++) begin
      int         slen, sel, hold;
      bit         gaps;
      logic [7:0] term, c;
      slen = $urandom_range(0, 40);
      sel  = $urandom_range(0, 15);
      gaps = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      term = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h0A;
      s = "";
      for (int k = 0; k < slen; k++) begin
        case ($urandom_range(0, 9))
          0:       c = 8'h20;
          1:       c = ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h0D;
          default: c = 8'($urandom_range(33, 126));
        endcase
        s = {s, " "};
        s[k] = c;
      end
      ew = model(s, sel, 255);
      en = model(s, sel, 15);
      sendString(s, term, sel, gaps);
      checkOutput($sformatf("rand%0d", r), ew, en, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
